// File: rtl/arm_pkg.sv
// arm_pkg: shared FSM encoding and constants for the ARM pipeline MEM stage.
package arm_pkg;

  // Memory-access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Byte address that maps to data-memory word 0
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  // Default number of ACCESS cycles tolerated before a timeout
  localparam int unsigned WAIT_MAX_DEFAULT = 32'd15;

  // Load data substituted when the memory never answers
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // A load returns data only when it is not also a store (the store wins)
  function automatic logic load_data_valid(input logic r_en, input logic w_en);
    return r_en & ~w_en;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load and bubble-insert control.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        bubble,
  input  logic        wb_en_d,
  input  logic        mem_r_en_d,
  input  logic [31:0] alu_result_d,
  input  logic [31:0] mem_data_d,
  input  logic [3:0]  dest_d,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result,
  output logic [31:0] mem_data,
  output logic [3:0]  dest
);

  // Load a new instruction, or inject a bubble by killing only the control bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      alu_result <= 32'd0;
      mem_data   <= 32'd0;
      dest       <= 4'd0;
    end else if (ld) begin
      wb_en      <= wb_en_d;
      mem_r_en   <= mem_r_en_d;
      alu_result <= alu_result_d;
      mem_data   <= mem_data_d;
      dest       <= dest_d;
    end else if (bubble) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
    end else begin
      wb_en      <= wb_en;
      mem_r_en   <= mem_r_en;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage sequencer. Issues one request per load/store,
// freezes upstream until the memory answers, and feeds the MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to abandon accesses after WAIT_MAX
// ACCESS cycles, returning TIMEOUT_DATA and pulsing err.
module mem_stage_ctrl
  import arm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_MAX  = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        freeze,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result,
  output logic [31:0] mem_data,
  output logic [3:0]  dest,
  output logic        err
);

  mem_state_e  state_r;
  mem_state_e  next_state_s;
  logic        mem_op_s;
  logic        timeout_s;
  logic        freeze_s;
  logic        mem_req_s;
  logic        ld_s;
  logic [31:0] data_r;
  logic [31:0] wb_data_s;
  logic [17:0] addr_diff_s;
  logic [1:0]  unused_addr_lsb_s;

  assign mem_op_s = mem_r_en_in | mem_w_en_in;

  // Only bits [17:2] of the offset form the word address; low 18 bits suffice
  assign addr_diff_s       = alu_result_in[17:0] - BASE_ADDR[17:0];
  assign unused_addr_lsb_s = addr_diff_s[1:0];

  // Reset gates the handshake and stall immediately, independent of the clock
  assign mem_req_s = ~rst & (state_r == ST_ACCESS);
  assign freeze_s  = ~rst & ((state_r == ST_ACCESS) |
                             ((state_r == ST_IDLE) & mem_op_s));

  assign mem_req   = mem_req_s;
  assign mem_we    = mem_req_s & mem_w_en_in;
  assign mem_addr  = rst ? 16'd0 : addr_diff_s[17:2];
  assign mem_wdata = rst ? 32'd0 : val_rm_in;
  assign freeze    = freeze_s;
  assign ld_s      = ~freeze_s;

  assign wb_data_s = load_data_valid(mem_r_en_in, mem_w_en_in) ? data_r : 32'd0;

`ifdef MEM_TIMEOUT_EN
  logic [31:0] wait_cnt_r;
  logic        err_r;

  assign timeout_s = (state_r == ST_ACCESS) & ~mem_ready &
                     (wait_cnt_r == 32'(WAIT_MAX - 32'd1));

  // Count unanswered ACCESS cycles; cleared whenever the FSM leaves ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 32'd0;
    end else if ((state_r == ST_ACCESS) && !mem_ready && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + 32'd1;
    end else begin
      wait_cnt_r <= 32'd0;
    end
  end

  // One-cycle error pulse during the DONE cycle that follows a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
    end
  end

  assign err = err_r;
`else
  localparam int unsigned unused_wait_max = WAIT_MAX;

  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; memory completion is only honoured in ACCESS
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ready || timeout_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Capture returned load data (or the timeout marker) for the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= 32'd0;
    end else if ((state_r == ST_ACCESS) && mem_ready) begin
      data_r <= mem_rdata;
    end else if (timeout_s) begin
      data_r <= TIMEOUT_DATA;
    end else begin
      data_r <= data_r;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .ld           (ld_s),
    .bubble       (freeze_s),
    .wb_en_d      (wb_en_in),
    .mem_r_en_d   (mem_r_en_in),
    .alu_result_d (alu_result_in),
    .mem_data_d   (wb_data_s),
    .dest_d       (dest_in),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .dest         (dest)
  );

endmodule
